// File: rtl/bcd_seq_pkg.sv
// Shared types and helpers for the BCD subtract sequencer.
package bcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    CONV_A,
    CONV_B,
    SUB1,
    SUB2,
    DAB,
    DONE
  } state_e;

  localparam int unsigned ITER_DEF = 7;
  localparam int unsigned BCD_MAX  = 99;
  // Binary magnitude width: enough bits for 0..BCD_MAX.
  localparam int unsigned MAG_W    = $clog2(BCD_MAX + 1);

  function automatic logic nib_ok(input logic [3:0] n);
    return (n <= 4'd9);
  endfunction

  // Double-dabble pre-shift correction for one BCD digit.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd2bin.sv
// Two-digit packed BCD to 7-bit binary (tens*10 + units); inputs assumed valid.
module bcd2bin (
  input  logic [7:0] bcd_i,
  output logic [6:0] bin_o
);

  logic [6:0] tens;
  logic [6:0] units;

  always_comb begin
    tens  = {3'b000, bcd_i[7:4]};
    units = {3'b000, bcd_i[3:0]};
    bin_o = (tens << 3) + (tens << 1) + units;
  end

endmodule

// File: rtl/diff.sv
// N-bit two's-complement difference a - b.
module diff #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] d_o
);

  assign d_o = a_i - b_i;

endmodule

// File: rtl/bcd_sub_seq.sv
// Multi-cycle |A-B| on 2-digit packed BCD with sign flag; one shared converter
// and one shared subtractor, result converted back by iterative double dabble.
module bcd_sub_seq
  import bcd_seq_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_bcd,
  input  logic [7:0] b_bcd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] res_bcd,
  output logic       neg,
  output logic       err
);

  localparam int unsigned CW = $clog2(ITER + 1);

  state_e             state_q, state_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [MAG_W-1:0]   bin_a_q, bin_a_d, bin_b_q, bin_b_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_w_q, neg_w_d;
  logic [7:0]         res_q, res_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;

  logic [7:0]         conv_in;
  logic [MAG_W-1:0]   conv_bin;
  logic [W-1:0]       op_x, op_y, d_w;
  logic [7:0]         bcd_adj;
  logic [7+MAG_W:0]   dd_shift;
  logic               nibs_ok;

  assign conv_in = (state_q == CONV_B) ? b_q : a_q;

  bcd2bin u_bcd2bin (
    .bcd_i (conv_in),
    .bin_o (conv_bin)
  );

  // SUB2 reuses the same subtractor with the operands swapped.
  assign op_x = (state_q == SUB2) ? {{(W-MAG_W){1'b0}}, bin_b_q}
                                  : {{(W-MAG_W){1'b0}}, bin_a_q};
  assign op_y = (state_q == SUB2) ? {{(W-MAG_W){1'b0}}, bin_a_q}
                                  : {{(W-MAG_W){1'b0}}, bin_b_q};

  diff #(.N(W)) u_diff (
    .a_i (op_x),
    .b_i (op_y),
    .d_o (d_w)
  );

  assign nibs_ok  = nib_ok(a_q[7:4]) && nib_ok(a_q[3:0]) &&
                    nib_ok(b_q[7:4]) && nib_ok(b_q[3:0]);
  assign bcd_adj  = {dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
  assign dd_shift = {bcd_adj, mag_q} << 1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bin_a_d = bin_a_q;
    bin_b_d = bin_b_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_w_d = neg_w_q;
    res_d   = res_q;
    neg_d   = neg_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_bcd;
          b_d     = b_bcd;
          state_d = CHK;
        end
      end
      CHK: begin
        if (!nibs_ok) begin
          res_d   = '0;
          neg_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = CONV_A;
        end
      end
      CONV_A: begin
        bin_a_d = conv_bin;
        state_d = CONV_B;
      end
      CONV_B: begin
        bin_b_d = conv_bin;
        state_d = SUB1;
      end
      SUB1: begin
        bcd_d = '0;
        cnt_d = '0;
        if (d_w[W-1]) begin
          neg_w_d = 1'b1;
          state_d = SUB2;
        end else begin
          neg_w_d = 1'b0;
          mag_d   = d_w[MAG_W-1:0];
          state_d = DAB;
        end
      end
      SUB2: begin
        mag_d   = d_w[MAG_W-1:0];
        state_d = DAB;
      end
      DAB: begin
        bcd_d = dd_shift[7+MAG_W:MAG_W];
        mag_d = dd_shift[MAG_W-1:0];
        cnt_d = cnt_q + CW'(1);
        // Visible outputs change only when the finished result is published.
        if (cnt_q == CW'(ITER - 1)) begin
          res_d   = dd_shift[7+MAG_W:MAG_W];
          neg_d   = neg_w_q;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bin_a_q <= '0;
      bin_b_q <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_w_q <= 1'b0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bin_a_q <= bin_a_d;
      bin_b_q <= bin_b_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_w_q <= neg_w_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res_bcd   = res_q;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed self-checking bench for bcd_sub_seq.
module tb_bcd_sub_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_bcd;
  logic [7:0] b_bcd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res_bcd;
  logic       neg;
  logic       err;

  int n_checks;
  int n_fail;

  bcd_sub_seq #(.W(8), .ITER(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_bcd   (res_bcd),
    .neg       (neg),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands, accept on the next edge, then count edges until out_valid.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, output int lat);
    in_valid = 1'b1;
    a_bcd    = a;
    b_bcd    = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (res_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_res got=%h exp=00", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got=%b exp=0", neg); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_positive();
    int lat;
    run_job(8'h45, 8'h12, lat);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL pos_latency got=%0d exp=11", lat); end
    n_checks++; if (res_bcd !== 8'h33) begin n_fail++; $display("FAIL pos_res got=%h exp=33", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL pos_neg got=%b exp=0", neg); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pos_err got=%b exp=0", err); end
    release_result();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pos_release_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pos_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_negative();
    int lat;
    run_job(8'h12, 8'h45, lat);
    n_checks++; if (lat != 12) begin n_fail++; $display("FAIL neg_latency got=%0d exp=12", lat); end
    n_checks++; if (res_bcd !== 8'h33) begin n_fail++; $display("FAIL neg_res got=%h exp=33", res_bcd); end
    n_checks++; if (neg !== 1'b1) begin n_fail++; $display("FAIL neg_flag got=%b exp=1", neg); end
    release_result();
  endtask

  task automatic test_err();
    int lat;
    run_job(8'h3A, 8'h10, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL err_latency got=%0d exp=1", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%b exp=1", err); end
    n_checks++; if (res_bcd !== 8'h00) begin n_fail++; $display("FAIL err_res got=%h exp=00", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL err_neg got=%b exp=0", neg); end
    release_result();
  endtask

  task automatic test_max();
    int lat;
    run_job(8'h99, 8'h00, lat);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL max_latency got=%0d exp=11", lat); end
    n_checks++; if (res_bcd !== 8'h99) begin n_fail++; $display("FAIL max_res got=%h exp=99", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL max_neg got=%b exp=0", neg); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL max_err got=%b exp=0", err); end
    release_result();
  endtask

  task automatic test_equal();
    int lat;
    run_job(8'h57, 8'h57, lat);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL eq_latency got=%0d exp=11", lat); end
    n_checks++; if (res_bcd !== 8'h00) begin n_fail++; $display("FAIL eq_res got=%h exp=00", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL eq_neg got=%b exp=0", neg); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_job(8'h80, 8'h25, lat);
    n_checks++; if (res_bcd !== 8'h55) begin n_fail++; $display("FAIL hold_first_res got=%h exp=55", res_bcd); end
    // Competing operands offered while DONE must be ignored.
    in_valid = 1'b1;
    a_bcd    = 8'h11;
    b_bcd    = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      n_checks++; if (res_bcd !== 8'h55) begin n_fail++; $display("FAIL hold_res cyc=%0d got=%h exp=55", i, res_bcd); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
    run_job(8'h23, 8'h68, lat);
    n_checks++; if (lat != 12) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=12", lat); end
    n_checks++; if (res_bcd !== 8'h45) begin n_fail++; $display("FAIL b2b_res got=%h exp=45", res_bcd); end
    n_checks++; if (neg !== 1'b1) begin n_fail++; $display("FAIL b2b_neg got=%b exp=1", neg); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    a_bcd    = 8'h12;
    b_bcd    = 8'h45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_checks++; if (res_bcd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_res got=%h exp=00", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL mid_rst_neg got=%b exp=0", neg); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(8'h45, 8'h12, lat);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=11", lat); end
    n_checks++; if (res_bcd !== 8'h33) begin n_fail++; $display("FAIL post_rst_res got=%h exp=33", res_bcd); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL post_rst_neg got=%b exp=0", neg); end
    release_result();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_bcd     = 8'h00;
    b_bcd     = 8'h00;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_positive();
    test_negative();
    test_err();
    test_max();
    test_equal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
